// File: rtl/word_splitter.sv
// word_splitter: 32-to-16 sequential width converter.
// Takes one 32-bit word per input handshake and emits it as two 16-bit
// beats, or as one beat when SKIP_ZERO_HI is set and the upper half is zero.
//
// Handshake rule (both sides): a transfer happens on a rising clk edge
// where valid && ready are both high. valid, once raised, holds with stable
// data/last until accepted. in_ready may depend combinationally on
// out_ready so a new word can be loaded in the same cycle the last beat
// of the previous word leaves (zero-bubble back-to-back words).
module word_splitter #(
  parameter bit LOW_FIRST    = 1'b1,
  parameter bit SKIP_ZERO_HI = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic [7:0]  words_sent,
  output logic [1:0]  o_state_dbg
);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_FIRST  = 2'd1,
    S_SECOND = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_word;
  logic        r_skip;
  logic        r_out_valid;
  logic [15:0] r_out_data;
  logic        r_out_last;
  logic [7:0]  r_words_sent;

  logic        w_in_hs;
  logic        w_out_hs;
  logic        w_last_hs;
  logic        w_skip_new;
  logic [15:0] w_first_half;
  logic [15:0] w_second_half;

  // Handshake decode; in_ready opens when empty or when the last beat leaves.
  assign w_out_hs   = r_out_valid && out_ready;
  assign w_last_hs  = w_out_hs && r_out_last;
  assign in_ready   = rst_n && ((r_state == S_EMPTY) || w_last_hs);
  assign w_in_hs    = in_valid && in_ready;

  // A zero upper half collapses to a single low-half beat only when enabled.
  assign w_skip_new    = SKIP_ZERO_HI && (in_data[31:16] == 16'h0000);
  assign w_first_half  = (LOW_FIRST || w_skip_new) ? in_data[15:0] : in_data[31:16];
  assign w_second_half = LOW_FIRST ? r_word[31:16] : r_word[15:0];

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign words_sent  = r_words_sent;
  assign o_state_dbg = r_state;

  // Single FSM: holds the word, sequences the beats and registers every output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_word       <= 32'h0;
      r_skip       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 16'h0;
      r_out_last   <= 1'b0;
      r_words_sent <= 8'h0;
    end else begin
      if (w_in_hs) begin
        // New word: legal only from EMPTY or alongside the last-beat handshake.
        r_state     <= S_FIRST;
        r_word      <= in_data;
        r_skip      <= w_skip_new;
        r_out_valid <= 1'b1;
        r_out_data  <= w_first_half;
        r_out_last  <= w_skip_new;
      end else if (w_out_hs) begin
        if ((r_state == S_FIRST) && !r_skip) begin
          r_state    <= S_SECOND;
          r_out_data <= w_second_half;
          r_out_last <= 1'b1;
        end else begin
          r_state     <= S_EMPTY;
          r_out_valid <= 1'b0;
          r_out_data  <= 16'h0;
          r_out_last  <= 1'b0;
        end
      end
      // Without an output handshake everything holds, keeping beats stable.
      if (w_last_hs) begin
        r_words_sent <= r_words_sent + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_word_splitter.sv
// Directed bench for word_splitter: three instances cover LOW_FIRST/SKIP_ZERO_HI
// combinations. Inputs change 1 time unit after a rising edge; outputs are
// checked 2 time units after the edge, well clear of the next edge.
module tb_word_splitter;

  logic clk;
  logic rst_n;

  // Instance a: LOW_FIRST=1, SKIP_ZERO_HI=0
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
  logic [31:0] a_in_data;
  logic [15:0] a_out_data;
  logic [7:0]  a_words;
  logic [1:0]  a_state;
  // Instance b: LOW_FIRST=1, SKIP_ZERO_HI=1
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  logic [31:0] b_in_data;
  logic [15:0] b_out_data;
  logic [7:0]  b_words;
  logic [1:0]  b_state;
  // Instance c: LOW_FIRST=0, SKIP_ZERO_HI=0
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last;
  logic [31:0] c_in_data;
  logic [15:0] c_out_data;
  logic [7:0]  c_words;
  logic [1:0]  c_state;

  int n_vec;
  int n_err;
  logic [7:0] a_exp_words;
  logic [7:0] b_exp_words;
  logic [7:0] c_exp_words;

  word_splitter #(.LOW_FIRST(1'b1), .SKIP_ZERO_HI(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_last(a_out_last), .words_sent(a_words),
    .o_state_dbg(a_state));

  word_splitter #(.LOW_FIRST(1'b1), .SKIP_ZERO_HI(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_last(b_out_last), .words_sent(b_words),
    .o_state_dbg(b_state));

  word_splitter #(.LOW_FIRST(1'b0), .SKIP_ZERO_HI(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_last(c_out_last), .words_sent(c_words),
    .o_state_dbg(c_state));

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = 32'h0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = 32'h0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_data = 32'h0; c_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 a_in_valid = 1'b1;
    #1;
    n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", a_in_ready); end
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    n_vec++; if (a_out_data !== 16'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0000", a_out_data); end
    n_vec++; if (a_out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b want 0", a_out_last); end
    n_vec++; if (a_words !== 8'h00) begin n_err++; $display("FAIL reset_words: got %h want 00", a_words); end
    n_vec++; if (a_state !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", a_state); end
    a_in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", a_in_ready); end
    a_exp_words = 8'h00; b_exp_words = 8'h00; c_exp_words = 8'h00;
  endtask

  task automatic test_basic();
    a_in_valid = 1'b1; a_in_data = 32'hDEADBEEF; a_out_ready = 1'b1;
    @(posedge clk);
    #1 a_in_valid = 1'b0; a_in_data = 32'h0;
    #1;
    n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL basic_b0_valid: got %b want 1", a_out_valid); end
    n_vec++; if (a_out_data !== 16'hBEEF) begin n_err++; $display("FAIL basic_b0_data: got %h want BEEF", a_out_data); end
    n_vec++; if (a_out_last !== 1'b0) begin n_err++; $display("FAIL basic_b0_last: got %b want 0", a_out_last); end
    n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL basic_b0_in_ready: got %b want 0", a_in_ready); end
    @(posedge clk); #2;
    n_vec++; if (a_out_data !== 16'hDEAD) begin n_err++; $display("FAIL basic_b1_data: got %h want DEAD", a_out_data); end
    n_vec++; if (a_out_last !== 1'b1) begin n_err++; $display("FAIL basic_b1_last: got %b want 1", a_out_last); end
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL basic_b1_in_ready: got %b want 1", a_in_ready); end
    @(posedge clk); #2;
    a_exp_words = a_exp_words + 8'd1;
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL basic_done_valid: got %b want 0", a_out_valid); end
    n_vec++; if (a_out_data !== 16'h0) begin n_err++; $display("FAIL basic_done_data: got %h want 0000", a_out_data); end
    n_vec++; if (a_words !== a_exp_words) begin n_err++; $display("FAIL basic_words: got %h want %h", a_words, a_exp_words); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_data [4];
    logic        exp_last [4];
    exp_data = '{16'h2222, 16'h1111, 16'h4444, 16'h3333};
    exp_last = '{1'b0, 1'b1, 1'b0, 1'b1};
    a_in_valid = 1'b1; a_in_data = 32'h11112222; a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) a_in_data = 32'h33334444;
      if (i == 2) begin a_in_valid = 1'b0; a_in_data = 32'h0; end
      #1;
      n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, a_out_valid); end
      n_vec++; if (a_out_data !== exp_data[i]) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, a_out_data, exp_data[i]); end
      n_vec++; if (a_out_last !== exp_last[i]) begin n_err++; $display("FAIL b2b_last[%0d]: got %b want %b", i, a_out_last, exp_last[i]); end
      n_vec++; if (a_in_ready !== exp_last[i]) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want %b", i, a_in_ready, exp_last[i]); end
    end
    @(posedge clk); #2;
    a_exp_words = a_exp_words + 8'd2;
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_done_valid: got %b want 0", a_out_valid); end
    n_vec++; if (a_words !== a_exp_words) begin n_err++; $display("FAIL b2b_words: got %h want %h", a_words, a_exp_words); end
  endtask

  task automatic test_backpressure();
    a_in_valid = 1'b1; a_in_data = 32'hDEADBEEF; a_out_ready = 1'b1;
    @(posedge clk);
    #1 a_in_valid = 1'b0; a_in_data = 32'h0;
    @(posedge clk);
    #1 a_out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) begin @(posedge clk); #2; end
      n_vec++; if (a_out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", k, a_out_valid); end
      n_vec++; if (a_out_data !== 16'hDEAD) begin n_err++; $display("FAIL bp_data[%0d]: got %h want DEAD", k, a_out_data); end
      n_vec++; if (a_out_last !== 1'b1) begin n_err++; $display("FAIL bp_last[%0d]: got %b want 1", k, a_out_last); end
      n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, a_in_ready); end
      n_vec++; if (a_words !== a_exp_words) begin n_err++; $display("FAIL bp_words_hold[%0d]: got %h want %h", k, a_words, a_exp_words); end
    end
    @(posedge clk);
    #1 a_out_ready = 1'b1;
    #1;
    n_vec++; if (a_out_data !== 16'hDEAD) begin n_err++; $display("FAIL bp_release_data: got %h want DEAD", a_out_data); end
    n_vec++; if (a_in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_in_ready: got %b want 1", a_in_ready); end
    @(posedge clk); #2;
    a_exp_words = a_exp_words + 8'd1;
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL bp_done_valid: got %b want 0", a_out_valid); end
    n_vec++; if (a_words !== a_exp_words) begin n_err++; $display("FAIL bp_words: got %h want %h", a_words, a_exp_words); end
  endtask

  task automatic test_skip();
    // Zero upper half collapses to one beat, then a same-cycle reload.
    b_in_valid = 1'b1; b_in_data = 32'h0000ABCD; b_out_ready = 1'b1;
    @(posedge clk);
    #1 b_in_data = 32'h00005678;
    #1;
    n_vec++; if (b_out_data !== 16'hABCD) begin n_err++; $display("FAIL skip_data: got %h want ABCD", b_out_data); end
    n_vec++; if (b_out_last !== 1'b1) begin n_err++; $display("FAIL skip_last: got %b want 1", b_out_last); end
    n_vec++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL skip_in_ready: got %b want 1", b_in_ready); end
    @(posedge clk);
    #1 b_in_valid = 1'b0; b_in_data = 32'h0;
    #1;
    b_exp_words = b_exp_words + 8'd1;
    n_vec++; if (b_out_data !== 16'h5678) begin n_err++; $display("FAIL skip_reload_data: got %h want 5678", b_out_data); end
    n_vec++; if (b_out_last !== 1'b1) begin n_err++; $display("FAIL skip_reload_last: got %b want 1", b_out_last); end
    n_vec++; if (b_words !== b_exp_words) begin n_err++; $display("FAIL skip_words1: got %h want %h", b_words, b_exp_words); end
    @(posedge clk); #2;
    b_exp_words = b_exp_words + 8'd1;
    n_vec++; if (b_out_valid !== 1'b0) begin n_err++; $display("FAIL skip_done_valid: got %b want 0", b_out_valid); end
    n_vec++; if (b_words !== b_exp_words) begin n_err++; $display("FAIL skip_words2: got %h want %h", b_words, b_exp_words); end
    // Non-zero upper half still splits into two beats.
    b_in_valid = 1'b1; b_in_data = 32'h0001ABCD;
    @(posedge clk);
    #1 b_in_valid = 1'b0; b_in_data = 32'h0;
    #1;
    n_vec++; if (b_out_data !== 16'hABCD) begin n_err++; $display("FAIL noskip_b0_data: got %h want ABCD", b_out_data); end
    n_vec++; if (b_out_last !== 1'b0) begin n_err++; $display("FAIL noskip_b0_last: got %b want 0", b_out_last); end
    @(posedge clk); #2;
    n_vec++; if (b_out_data !== 16'h0001) begin n_err++; $display("FAIL noskip_b1_data: got %h want 0001", b_out_data); end
    n_vec++; if (b_out_last !== 1'b1) begin n_err++; $display("FAIL noskip_b1_last: got %b want 1", b_out_last); end
    @(posedge clk); #2;
    b_exp_words = b_exp_words + 8'd1;
    n_vec++; if (b_words !== b_exp_words) begin n_err++; $display("FAIL noskip_words: got %h want %h", b_words, b_exp_words); end
    // With skipping disabled, a zero upper half is still sent as a beat.
    a_in_valid = 1'b1; a_in_data = 32'h0000ABCD; a_out_ready = 1'b1;
    @(posedge clk);
    #1 a_in_valid = 1'b0; a_in_data = 32'h0;
    #1;
    n_vec++; if (a_out_last !== 1'b0) begin n_err++; $display("FAIL skipoff_b0_last: got %b want 0", a_out_last); end
    @(posedge clk); #2;
    n_vec++; if (a_out_data !== 16'h0000 || a_out_last !== 1'b1 || a_out_valid !== 1'b1) begin
      n_err++; $display("FAIL skipoff_b1: got data=%h last=%b valid=%b want 0000/1/1", a_out_data, a_out_last, a_out_valid);
    end
    @(posedge clk); #2;
    a_exp_words = a_exp_words + 8'd1;
  endtask

  task automatic test_high_first();
    c_in_valid = 1'b1; c_in_data = 32'hDEADBEEF; c_out_ready = 1'b1;
    @(posedge clk);
    #1 c_in_valid = 1'b0; c_in_data = 32'h0;
    #1;
    n_vec++; if (c_out_data !== 16'hDEAD) begin n_err++; $display("FAIL hifirst_b0_data: got %h want DEAD", c_out_data); end
    n_vec++; if (c_out_last !== 1'b0) begin n_err++; $display("FAIL hifirst_b0_last: got %b want 0", c_out_last); end
    @(posedge clk); #2;
    n_vec++; if (c_out_data !== 16'hBEEF) begin n_err++; $display("FAIL hifirst_b1_data: got %h want BEEF", c_out_data); end
    n_vec++; if (c_out_last !== 1'b1) begin n_err++; $display("FAIL hifirst_b1_last: got %b want 1", c_out_last); end
    @(posedge clk); #2;
    c_exp_words = c_exp_words + 8'd1;
    n_vec++; if (c_words !== c_exp_words) begin n_err++; $display("FAIL hifirst_words: got %h want %h", c_words, c_exp_words); end
  endtask

  task automatic test_reset_mid();
    a_in_valid = 1'b1; a_in_data = 32'hDEADBEEF; a_out_ready = 1'b1;
    @(posedge clk);
    #1 a_in_valid = 1'b0; a_in_data = 32'h0;
    @(posedge clk);
    #1 a_out_ready = 1'b0; rst_n = 1'b0;
    #1;
    n_vec++; if (a_in_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_in_ready: got %b want 0", a_in_ready); end
    n_vec++; if (a_words === 8'h00) begin n_err++; $display("FAIL rstmid_words_before: got %h want nonzero", a_words); end
    @(posedge clk);
    #1 rst_n = 1'b1; a_out_ready = 1'b1;
    #1;
    a_exp_words = 8'h00; b_exp_words = 8'h00; c_exp_words = 8'h00;
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", a_out_valid); end
    n_vec++; if (a_out_data !== 16'h0) begin n_err++; $display("FAIL rstmid_data: got %h want 0000", a_out_data); end
    n_vec++; if (a_words !== a_exp_words) begin n_err++; $display("FAIL rstmid_words: got %h want %h", a_words, a_exp_words); end
    n_vec++; if (a_state !== 2'd0) begin n_err++; $display("FAIL rstmid_state: got %0d want 0", a_state); end
    @(posedge clk); #2;
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_no_beat: got %b want 0", a_out_valid); end
  endtask

  task automatic test_wrap();
    int cnt;
    cnt = 0;
    a_in_valid = 1'b1; a_in_data = 32'h00010002; a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 2000 && cnt < 256; cyc++) begin
      @(posedge clk);
      #1 a_in_data = a_in_data + 32'h00010001;
      #1;
      if (a_out_valid && a_out_last) begin
        cnt++;
        if (cnt == 256) begin
          a_in_valid = 1'b0;
          n_vec++; if (a_words !== 8'hFF) begin n_err++; $display("FAIL wrap_pre: got %h want FF", a_words); end
        end
      end
    end
    n_vec++; if (cnt != 256) begin n_err++; $display("FAIL wrap_timeout: got %0d words want 256", cnt); end
    @(posedge clk); #2;
    n_vec++; if (a_words !== 8'h00) begin n_err++; $display("FAIL wrap_words: got %h want 00", a_words); end
    n_vec++; if (a_out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_idle: got %b want 0", a_out_valid); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_skip();
    test_high_first();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
